// File: rtl/nios_sd_loader_irq_pkg.sv
// rtl/nios_sd_loader_irq_pkg.sv - register map constants and vector helper for the irq controller
package nios_sd_loader_irq_pkg;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;

  localparam int VEC_VALID_BIT = 15;
  localparam int MAX_IRQ       = 15;

  // Scanning downward lets the lowest-numbered set bit overwrite the others.
  function automatic logic [3:0] lowest_set_idx(input logic [MAX_IRQ-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/nios_sd_loader_irq_sync.sv
// rtl/nios_sd_loader_irq_sync.sv - multi-bit 2-flop synchronizer for asynchronous irq sources
module nios_sd_loader_irq_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/nios_sd_loader_irq_ctrl.sv
// rtl/nios_sd_loader_irq_ctrl.sv - Avalon-MM interrupt controller with level/edge sources and priority vector
module nios_sd_loader_irq_ctrl
  import nios_sd_loader_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               chipselect,
  input  logic [2:0]         address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] sync2;
  logic [NUM_IRQ-1:0] sync2_d;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] edge_mode;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] wdata;
  logic [MAX_IRQ-1:0] active_ext;
  logic               wr_en;
  logic               pend_wr;
  logic               mask_wr;
  logic               edge_wr;
  logic [15:0]        vector;
  logic [15:0]        rd_mux;
  logic               unused_wdata;

  nios_sd_loader_irq_sync #(.WIDTH(NUM_IRQ)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (irq_in),
    .q       (sync2)
  );

  assign wr_en        = chipselect && !write_n;
  assign pend_wr      = wr_en && (address == ADDR_PENDING);
  assign mask_wr      = wr_en && (address == ADDR_MASK);
  assign edge_wr      = wr_en && (address == ADDR_EDGE);
  assign wdata        = writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^writedata;
  assign active       = pending & mask;
  assign active_ext   = MAX_IRQ'(active);

  // Switching a bit into edge mode discards whatever level state it carried;
  // in edge mode a fresh rising edge beats a same-cycle W1C.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (edge_wr && wdata[i] && !edge_mode[i])
        pending_nxt[i] = 1'b0;
      else if (edge_mode[i])
        pending_nxt[i] = (sync2[i] & ~sync2_d[i]) | (pending[i] & ~(pend_wr & wdata[i]));
      else
        pending_nxt[i] = sync2[i];
    end
  end

  always_comb begin
    vector                = '0;
    vector[VEC_VALID_BIT] = |active;
    vector[3:0]           = lowest_set_idx(active_ext);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_PENDING: rd_mux = 16'(pending);
      ADDR_MASK:    rd_mux = 16'(mask);
      ADDR_EDGE:    rd_mux = 16'(edge_mode);
      ADDR_VECTOR:  rd_mux = vector;
      ADDR_RAW:     rd_mux = 16'(sync2);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync2_d   <= '0;
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
      readdata  <= '0;
      irq_out   <= 1'b0;
    end else begin
      sync2_d  <= sync2;
      pending  <= pending_nxt;
      if (mask_wr) mask <= wdata;
      if (edge_wr) edge_mode <= wdata;
      readdata <= rd_mux;
      irq_out  <= |active;
    end
  end

endmodule
